// File: rtl/tcp_pkg.sv
// Shared TCP engine types: flow/index widths, RX buffer index entry, table FSM states.
package tcp_pkg;
   localparam int unsigned MAX_FLOW_CNT     = 8;
   localparam int unsigned FLOWID_W         = $clog2(MAX_FLOW_CNT);
   localparam int unsigned RX_PAYLOAD_IDX_W = 4;

   // Buffer index with a wrap bit on top
   typedef logic [RX_PAYLOAD_IDX_W:0] tcp_buf_idx;

   typedef struct packed {
      tcp_buf_idx head;
      tcp_buf_idx commit;
      tcp_buf_idx tail;
      tcp_buf_idx used;
   } rx_idx_entry;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } idx_tbl_state_e;
endpackage

// File: rtl/rx_buf_idx_table_rd_port.sv
// One read port: write-first forwarding, occupancy derivation and a held response register.
module rx_idx_rd_port #(
   parameter int unsigned FLOWID_W = 3,
   parameter int unsigned IDX_W    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ready,
   input  logic                     req_val,
   input  logic [FLOWID_W-1:0]      req_addr,
   output logic                     req_rdy_c,
   output logic                     resp_val,
   input  logic                     resp_rdy,
   output logic [4*(IDX_W+1)-1:0]   resp_data,
   input  logic [IDX_W:0]           mem_head,
   input  logic [IDX_W:0]           mem_commit,
   input  logic [IDX_W:0]           mem_tail,
   input  logic                     head_we,
   input  logic [FLOWID_W-1:0]      head_wa,
   input  logic [IDX_W:0]           head_wd,
   input  logic                     commit_we,
   input  logic [FLOWID_W-1:0]      commit_wa,
   input  logic [IDX_W:0]           commit_wd,
   input  logic                     tail_we,
   input  logic [FLOWID_W-1:0]      tail_wa,
   input  logic [IDX_W:0]           tail_wd
);
   logic [IDX_W:0] head_f, commit_f, tail_f, used_f;
   logic           accept;

   // Same-cycle write to the flow being read wins over the stored value
   always_comb begin
      head_f   = (head_we   && head_wa   == req_addr) ? head_wd   : mem_head;
      commit_f = (commit_we && commit_wa == req_addr) ? commit_wd : mem_commit;
      tail_f   = (tail_we   && tail_wa   == req_addr) ? tail_wd   : mem_tail;
      used_f   = tail_f - head_f;
   end

   assign req_rdy_c = ready & (~resp_val | resp_rdy);
   assign accept    = req_val & req_rdy_c;

   always_ff @(posedge clk) begin
      if (!rst) begin
         resp_val <= 1'b0;
      end else if (accept) begin
         resp_val  <= 1'b1;
         resp_data <= {head_f, commit_f, tail_f, used_f};
      end else if (resp_rdy) begin
         resp_val <= 1'b0;
      end
   end
endmodule

// File: rtl/rx_buf_idx_table.sv
// Per-flow RX payload head/commit/tail index table with clear sweep and NUM_RD read ports.
module rx_buf_idx_table
   import tcp_pkg::*;
#(
   parameter int unsigned FLOWS    = MAX_FLOW_CNT,
   parameter int unsigned FLOWID_W = $clog2(FLOWS),
   parameter int unsigned IDX_W    = RX_PAYLOAD_IDX_W,
   parameter int unsigned NUM_RD   = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              new_flow_val,
   output logic                              new_flow_rdy,
   input  logic [FLOWID_W-1:0]               new_flow_flowid,
   input  logic [IDX_W:0]                    new_flow_head_idx,
   input  logic [IDX_W:0]                    new_flow_tail_idx,
   input  logic                              head_wr_req_val,
   output logic                              head_wr_req_rdy,
   input  logic [FLOWID_W-1:0]               head_wr_req_addr,
   input  logic [IDX_W:0]                    head_wr_req_data,
   input  logic                              commit_wr_req_val,
   output logic                              commit_wr_req_rdy,
   input  logic [FLOWID_W-1:0]               commit_wr_req_addr,
   input  logic [IDX_W:0]                    commit_wr_req_data,
   input  logic                              tail_wr_req_val,
   output logic                              tail_wr_req_rdy,
   input  logic [FLOWID_W-1:0]               tail_wr_req_addr,
   input  logic [IDX_W:0]                    tail_wr_req_data,
   input  logic [NUM_RD-1:0]                 rd_req_val,
   output logic [NUM_RD-1:0]                 rd_req_rdy,
   input  logic [NUM_RD*FLOWID_W-1:0]        rd_req_addr,
   output logic [NUM_RD-1:0]                 rd_resp_val,
   input  logic [NUM_RD-1:0]                 rd_resp_rdy,
   output logic [NUM_RD*4*(IDX_W+1)-1:0]     rd_resp_data,
   output logic                              init_done
);
   localparam int unsigned ENTRY_W = 4 * (IDX_W + 1);

   idx_tbl_state_e      state, state_next;
   logic [FLOWID_W-1:0] clr_addr, clr_addr_next;
   logic                ready_c, clr_we, nf_acc;

   logic                head_we, commit_we, tail_we;
   logic [FLOWID_W-1:0] head_wa, commit_wa, tail_wa;
   logic [IDX_W:0]      head_wd, commit_wd, tail_wd;

   logic [IDX_W:0] head_q   [FLOWS];
   logic [IDX_W:0] commit_q [FLOWS];
   logic [IDX_W:0] tail_q   [FLOWS];

   // Sweep state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_CLEAR;
         clr_addr  <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_next;
         clr_addr  <= clr_addr_next;
         init_done <= (state_next == ST_READY);
      end
   end

   always_comb begin
      state_next    = state;
      clr_addr_next = clr_addr;
      clr_we        = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_we        = 1'b1;
            clr_addr_next = clr_addr + FLOWID_W'(1);
            if (clr_addr == FLOWID_W'(FLOWS - 1)) begin
               state_next    = ST_READY;
               clr_addr_next = '0;
            end
         end
         ST_READY: ;
         default: state_next = ST_CLEAR;
      endcase
   end

   // Gated by rst so nothing is accepted on the edge that applies reset
   assign ready_c           = (state == ST_READY) & rst;
   assign new_flow_rdy      = ready_c;
   assign head_wr_req_rdy   = ready_c & ~new_flow_val;
   assign commit_wr_req_rdy = ready_c & ~new_flow_val;
   assign tail_wr_req_rdy   = ready_c & ~new_flow_val;

   // Per-bank write select: sweep, then new flow, then the field's own request
   always_comb begin
      nf_acc    = new_flow_val & ready_c;
      head_we   = clr_we | nf_acc | (head_wr_req_val & head_wr_req_rdy);
      commit_we = clr_we | nf_acc | (commit_wr_req_val & commit_wr_req_rdy);
      tail_we   = clr_we | nf_acc | (tail_wr_req_val & tail_wr_req_rdy);
      head_wa   = clr_we ? clr_addr : (nf_acc ? new_flow_flowid : head_wr_req_addr);
      commit_wa = clr_we ? clr_addr : (nf_acc ? new_flow_flowid : commit_wr_req_addr);
      tail_wa   = clr_we ? clr_addr : (nf_acc ? new_flow_flowid : tail_wr_req_addr);
      head_wd   = clr_we ? '0 : (nf_acc ? new_flow_head_idx : head_wr_req_data);
      commit_wd = clr_we ? '0 : (nf_acc ? new_flow_tail_idx : commit_wr_req_data);
      tail_wd   = clr_we ? '0 : (nf_acc ? new_flow_tail_idx : tail_wr_req_data);
   end

   always_ff @(posedge clk) begin
      if (head_we)   head_q[head_wa]     <= head_wd;
      if (commit_we) commit_q[commit_wa] <= commit_wd;
      if (tail_we)   tail_q[tail_wa]     <= tail_wd;
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [FLOWID_W-1:0] addr;
      assign addr = rd_req_addr[p*FLOWID_W +: FLOWID_W];

      rx_idx_rd_port #(
         .FLOWID_W (FLOWID_W),
         .IDX_W    (IDX_W)
      ) u_port (
         .clk        (clk),
         .rst        (rst),
         .ready      (ready_c),
         .req_val    (rd_req_val[p]),
         .req_addr   (addr),
         .req_rdy_c  (rd_req_rdy[p]),
         .resp_val   (rd_resp_val[p]),
         .resp_rdy   (rd_resp_rdy[p]),
         .resp_data  (rd_resp_data[p*ENTRY_W +: ENTRY_W]),
         .mem_head   (head_q[addr]),
         .mem_commit (commit_q[addr]),
         .mem_tail   (tail_q[addr]),
         .head_we    (head_we),
         .head_wa    (head_wa),
         .head_wd    (head_wd),
         .commit_we  (commit_we),
         .commit_wa  (commit_wa),
         .commit_wd  (commit_wd),
         .tail_we    (tail_we),
         .tail_wa    (tail_wa),
         .tail_wd    (tail_wd)
      );
   end
endmodule

// File: tb/tb_rx_buf_idx_table.sv
// Self-checking bench for rx_buf_idx_table: directed plan steps then randomized traffic vs a table model.
module tb_rx_buf_idx_table;
   import tcp_pkg::*;

   localparam int FL = 8;
   localparam int FW = 3;
   localparam int IW = 4;
   localparam int NR = 2;
   localparam int EW = 4 * (IW + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              nf_val, nf_rdy;
   logic [FW-1:0]     nf_id;
   logic [IW:0]       nf_head, nf_tail;
   logic              hw_val, hw_rdy, cw_val, cw_rdy, tw_val, tw_rdy;
   logic [FW-1:0]     hw_addr, cw_addr, tw_addr;
   logic [IW:0]       hw_data, cw_data, tw_data;
   logic [NR-1:0]     rd_val, rd_rdy, resp_val, resp_rdy;
   logic [NR*FW-1:0]  rd_addr;
   logic [NR*EW-1:0]  resp_data;
   logic              init_done;

   rx_buf_idx_table #(.FLOWS(FL), .FLOWID_W(FW), .IDX_W(IW), .NUM_RD(NR)) dut (
      .clk(clk), .rst(rst_n),
      .new_flow_val(nf_val), .new_flow_rdy(nf_rdy), .new_flow_flowid(nf_id),
      .new_flow_head_idx(nf_head), .new_flow_tail_idx(nf_tail),
      .head_wr_req_val(hw_val), .head_wr_req_rdy(hw_rdy),
      .head_wr_req_addr(hw_addr), .head_wr_req_data(hw_data),
      .commit_wr_req_val(cw_val), .commit_wr_req_rdy(cw_rdy),
      .commit_wr_req_addr(cw_addr), .commit_wr_req_data(cw_data),
      .tail_wr_req_val(tw_val), .tail_wr_req_rdy(tw_rdy),
      .tail_wr_req_addr(tw_addr), .tail_wr_req_data(tw_data),
      .rd_req_val(rd_val), .rd_req_rdy(rd_rdy), .rd_req_addr(rd_addr),
      .rd_resp_val(resp_val), .rd_resp_rdy(resp_rdy), .rd_resp_data(resp_data),
      .init_done(init_done)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: table contents, sweep progress, held responses
   logic [IW:0]  m_head [FL];
   logic [IW:0]  m_commit [FL];
   logic [IW:0]  m_tail [FL];
   logic         m_ready = 1'b0;
   int           m_cnt = 0;
   logic [NR-1:0] m_rv = '0;
   rx_idx_entry  m_rd [NR];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic rdy;
      rdy = m_ready & rst_n;
      chk("init_done", 64'(init_done), 64'(m_ready));
      chk("new_flow_rdy", 64'(nf_rdy), 64'(rdy));
      chk("wr_req_rdy", 64'({hw_rdy, cw_rdy, tw_rdy}), 64'({3{rdy & ~nf_val}}));
      for (int p = 0; p < NR; p++) begin
         chk($sformatf("rd_req_rdy%0d", p), 64'(rd_rdy[p]), 64'(rdy & (~m_rv[p] | resp_rdy[p])));
         chk($sformatf("resp_val%0d", p), 64'(resp_val[p]), 64'(m_rv[p]));
         if (m_rv[p])
            chk($sformatf("resp_data%0d", p), 64'(resp_data[p*EW +: EW]), 64'(m_rd[p]));
      end
   endtask

   // Apply the effect of the coming clock edge: writes land first, reads see them
   task automatic model_step();
      logic [IW:0] nh [FL];
      logic [IW:0] nc [FL];
      logic [IW:0] nt [FL];
      logic        rdy;
      logic [FW-1:0] a;
      rdy = m_ready & rst_n;
      nh = m_head; nc = m_commit; nt = m_tail;
      if (rdy && nf_val) begin
         nh[nf_id] = nf_head; nc[nf_id] = nf_tail; nt[nf_id] = nf_tail;
      end else if (rdy) begin
         if (hw_val) nh[hw_addr] = hw_data;
         if (cw_val) nc[cw_addr] = cw_data;
         if (tw_val) nt[tw_addr] = tw_data;
      end
      for (int p = 0; p < NR; p++) begin
         a = rd_addr[p*FW +: FW];
         if (rd_val[p] && rdy && (!m_rv[p] || resp_rdy[p])) begin
            m_rd[p] = '{head: nh[a], commit: nc[a], tail: nt[a], used: (IW+1)'(nt[a] - nh[a])};
            m_rv[p] = 1'b1;
         end else if (resp_rdy[p]) begin
            m_rv[p] = 1'b0;
         end
      end
      m_head = nh; m_commit = nc; m_tail = nt;
      if (!rst_n) begin
         m_ready = 1'b0; m_cnt = 0; m_rv = '0;
      end else if (!m_ready) begin
         m_cnt++;
         if (m_cnt == FL) begin
            m_ready = 1'b1;
            for (int i = 0; i < FL; i++) begin
               m_head[i] = '0; m_commit[i] = '0; m_tail[i] = '0;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      nf_val = 0; hw_val = 0; cw_val = 0; tw_val = 0; rd_val = '0;
   endtask

   function automatic logic [IW:0] port_field(input int p, input int f);
      logic [EW-1:0] e;
      e = resp_data[p*EW +: EW];
      return e[(3-f)*(IW+1) +: (IW+1)];
   endfunction

   initial begin
      rst_n = 0; idle(); resp_rdy = '1;
      nf_id = '0; nf_head = '0; nf_tail = '0;
      hw_addr = '0; hw_data = '0; cw_addr = '0; cw_data = '0; tw_addr = '0; tw_data = '0;
      rd_addr = '0;

      // Clear sweep while polling with reads
      repeat (3) tick();
      rst_n = 1; rd_val = '1; rd_addr = {3'd7, 3'd0};
      repeat (7) tick();
      chk("sweep_not_done", 64'(init_done), 64'(0));
      tick();
      chk("sweep_done", 64'(init_done), 64'(1));
      for (int i = 0; i < FL; i++) begin
         rd_addr = {FW'(FL - 1 - i), FW'(i)};
         tick();
      end
      rd_val = '0; tick();

      // New flow initialisation
      nf_val = 1; nf_id = 3; nf_head = 5; nf_tail = 5;
      tick();
      nf_val = 0; rd_val = 2'b01; rd_addr = {3'd0, 3'd3};
      tick();
      chk("nf_read", 64'(resp_data[EW-1:0]), 64'({5'd5, 5'd5, 5'd5, 5'd0}));
      rd_val = '0;

      // Arbitration: head write blocked by new flow, commits next cycle
      nf_val = 1; nf_id = 6; nf_head = 2; nf_tail = 2;
      hw_val = 1; hw_addr = 6; hw_data = 9;
      tick();
      nf_val = 0;
      tick();
      hw_val = 0; rd_val = 2'b01; rd_addr = {3'd0, 3'd6};
      tick();
      chk("arb_head", 64'(port_field(0, 0)), 64'(9));
      rd_val = '0;

      // Forwarding across the wrap bit
      tw_val = 1; tw_addr = 3; tw_data = 5'h12; rd_val = 2'b01; rd_addr = {3'd0, 3'd3};
      tick();
      chk("fwd_tail", 64'(port_field(0, 2)), 64'(5'h12));
      chk("fwd_used", 64'(port_field(0, 3)), 64'(5'h0D));
      hw_val = 1; hw_addr = 3; hw_data = 5'h12; tw_data = 5'h02;
      tick();
      chk("full_used", 64'(port_field(0, 3)), 64'(5'h10));
      idle();

      // Stall isolation: port 1 held while port 0 streams
      resp_rdy = 2'b01; rd_val = 2'b11; rd_addr = {3'd3, 3'd3};
      tw_val = 1; tw_addr = 3; tw_data = 5'h07;
      tick();
      for (int i = 0; i < 4; i++) begin
         tw_data = 5'(8 + i);
         tick();
      end
      chk("stall_p1_tail", 64'(port_field(1, 2)), 64'(5'h07));
      chk("stream_p0_tail", 64'(port_field(0, 2)), 64'(5'h0B));
      idle(); resp_rdy = '1;
      tick();

      // Reset mid-sweep restarts from 0
      rst_n = 0; tick();
      rst_n = 1;
      repeat (5) tick();
      rst_n = 0; tick();
      rst_n = 1;
      repeat (7) tick();
      chk("resweep_not_done", 64'(init_done), 64'(0));
      tick();
      chk("resweep_done", 64'(init_done), 64'(1));

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         nf_val   = ($urandom_range(0, 7) == 0);
         nf_id    = FW'($urandom);
         nf_head  = (IW+1)'($urandom);
         nf_tail  = (IW+1)'($urandom);
         hw_val   = 1'($urandom); hw_addr = FW'($urandom); hw_data = (IW+1)'($urandom);
         cw_val   = 1'($urandom); cw_addr = FW'($urandom); cw_data = (IW+1)'($urandom);
         tw_val   = 1'($urandom); tw_addr = FW'($urandom); tw_data = (IW+1)'($urandom);
         rd_val   = NR'($urandom);
         rd_addr  = (NR*FW)'($urandom);
         resp_rdy = NR'($urandom | $urandom);
         tick();
      end
      rst_n = 1; idle(); resp_rdy = '1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rx_buf_idx_table.md
# rx_buf_idx_table

Per-flow RX payload buffer index table for the TCP engine: head, commit, and tail indices for every flow in one block, with a parametrised number of read ports, each returning all three fields plus derived occupancy. It replaces the separate per-field RAM instances in the RX payload path. It adds a post-reset clear sweep, write-to-read forwarding, and new-flow initialisation with priority over per-field writes.

## Interface
Parameters:
- FLOWS, default MAX_FLOW_CNT: number of flow entries; power of two, ≥2.
- FLOWID_W, default $clog2(FLOWS): flow address width.
- IDX_W, default RX_PAYLOAD_IDX_W: buffer index width; stored indices carry a wrap bit, so each is IDX_W+1 bits.
- NUM_RD, default 2: read port count, 1..4.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-low.
- new_flow_val / new_flow_rdy  in/out  1  initialise one flow.
- new_flow_flowid  in  FLOWID_W  flow to initialise.
- new_flow_head_idx  in  IDX_W+1  initial head.
- new_flow_tail_idx  in  IDX_W+1  initial tail; also written to commit.
- {head,commit,tail}_wr_req_val / _rdy  in/out  1 each  per-field write handshake.
- {head,commit,tail}_wr_req_addr  in  FLOWID_W each  target flow.
- {head,commit,tail}_wr_req_data  in  IDX_W+1 each  new index.
- rd_req_val / rd_req_rdy  in/out  NUM_RD  per-port read request handshake.
- rd_req_addr  in  NUM_RD*FLOWID_W  packed per-port read address; port p at [p*FLOWID_W +: FLOWID_W].
- rd_resp_val / rd_resp_rdy  out/in  NUM_RD  per-port response handshake.
- rd_resp_data  out  NUM_RD*$bits(rx_idx_entry)  packed {head, commit, tail, used}.
- init_done  out  1  high once the clear sweep completes.

## Operation
- FSM states:
  - CLEAR: on reset, walks addresses 0..FLOWS-1, writing head=commit=tail=0, one entry per cycle. All *_rdy are low throughout.
  - READY: entered the cycle after address FLOWS-1 is written. init_done rises on entry and stays high until the next reset.
- Writes: each field is an independent bank, so head, commit, and tail writes may all commit in one cycle, to the same flow or different flows.
- new_flow arbitration:
  - new_flow has priority over the per-field writes.
  - new_flow_rdy = READY.
  - Each field's wr_req_rdy = READY & ~new_flow_val.
  - An accepted new_flow writes head=new_flow_head_idx, commit=tail=new_flow_tail_idx.
- Read accept: port p accepts when rd_req_val[p] & rd_req_rdy[p], where rd_req_rdy[p] = READY & (~rd_resp_val[p] | rd_resp_rdy[p]). Ports are fully independent; all NUM_RD ports may read the same address in the same cycle.
- Forwarding: if a write commits in the same cycle as a read accept to the same flow, the response carries the newly written value for that field (write-first).
- Stalled response: the response is a snapshot taken at accept. Later writes do not alter a response held under rd_resp_rdy=0.
- used: computed as (tail - head) mod 2^(IDX_W+1), width IDX_W+1.
  - 0 means empty.
  - 2^IDX_W means full.
  - Larger values are impossible; the block does not check for them.

## Timing
- Reset: rd_resp_val=0, all *_rdy=0, init_done=0, FSM=CLEAR, sweep address=0. A reset asserted mid-sweep or mid-traffic restarts the sweep at 0, and in-flight responses are dropped.
- Clear sweep: takes exactly FLOWS cycles after rst deasserts. init_done is high on cycle FLOWS.
- Read latency: 1 cycle. Accept in cycle n gives rd_resp_val in cycle n+1.
- Back-to-back reads: with rd_resp_rdy held high, a port sustains 1 read/cycle.
- Response hold: rd_resp_val and rd_resp_data are held stable until rd_resp_rdy. An accept and a drain in the same cycle replace the response with no bubble.
- Write visibility: a write committed in cycle n is visible to a read accepted in cycle n (forwarded) or later.

## Structure
- tcp_pkg holds:
  - MAX_FLOW_CNT, FLOWID_W, RX_PAYLOAD_IDX_W;
  - tcp_buf_idx;
  - new typedef rx_idx_entry: packed {head, commit, tail, used}, each IDX_W+1 bits, using RX_PAYLOAD_IDX_W.
- Storage: flop arrays, one per field, with NUM_RD combinational read muxes.
- Sub-module rx_idx_rd_port: one per read port, via generate. It contains the response register, the valid/ready logic, and forwarding compare for all three fields.

## Test plan
- Clear sweep: FLOWS=8. Deassert rst, poll with reads → init_done at cycle 8; rdy low before that; every flow then reads {0,0,0,used=0}.
- New flow: new_flow flow 3, head=5, tail=5 → read flow 3 returns {5,5,5,0}.
- Arbitration: new_flow and head_wr_req both valid in one cycle → head_wr_req_rdy=0 that cycle, and the head write commits the following cycle.
- Forwarding with wrap: IDX_W=4. Write tail=0x12 to flow 3 (head=0x05) in the same cycle as a port-0 read of flow 3 → response tail=0x12, used=0x0D. Then set head=0x12, tail=0x02 → used=0x10, the full value.
- Stall isolation: NUM_RD=2. Port 1 response stalled 4 cycles while flow 3 tail is rewritten → port 1 data unchanged; port 0 keeps 1 read/cycle with the new tail.
- Mid-sweep reset: assert rst at sweep address 5 → sweep restarts at 0, init_done stays low until FLOWS cycles after release.
